// File: rtl/result_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_display_pkg
// Description : Shared constants, converter state encoding, 7-segment
//               patterns and the double-dabble digit-adjust helper used by
//               result_display and seg7_decode.
// Revision    : 1.0 - initial release
// ============================================================================
package result_display_pkg;

  // Geometry of the displayed result
  localparam int DIGITS = 5;
  localparam int DATA_W = 14;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int STEP_W = 4;

  // Number of double-dabble steps, one per input bit
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DATA_W);

  // Converter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Active-low segment patterns, bit6 = g ... bit0 = a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Code fed to the decoder to force a blank digit (any of 10..15 works)
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Double-dabble pre-shift correction: every BCD digit >= 5 gets +3 so
  // that the following left shift carries correctly into the next digit.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational BCD to active-low 7-segment decoder. Codes
//               10..15 decode to a blank digit.
// Ports       : code - 4-bit BCD digit in
//               seg  - active-low segments out, bit6 = g ... bit0 = a
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
  import result_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
// Module      : result_display
// Description : Converts the 14-bit processor result to 5-digit BCD with a
//               serial double-dabble FSM and scans it onto a multiplexed,
//               active-low 7-segment display with leading-zero blanking.
// Ports       : clk       - single clock, rising edge
//               rst_n     - synchronous active-low reset
//               resultado - 14-bit unsigned value to display
//               bcd       - registered packed BCD, digit 4 in [19:16]
//               done      - one-cycle pulse when bcd takes a new value
//               busy      - high while a conversion is in progress
//               seg       - active-low segments of the selected digit
//               an        - active-low one-hot digit enable, an[0] = LSD
// Parameters  : REFRESH_DIV - cycles each digit stays selected (2..2^20)
// Revision    : 1.0 - initial release
// ============================================================================
module result_display
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] resultado,
  output logic [BCD_W-1:0]  bcd,
  output logic              done,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  // --------------------------------------------------------------------------
  // Converter
  // --------------------------------------------------------------------------
  conv_state_t       state, state_next;
  logic [DATA_W-1:0] captured, captured_next;
  logic [BCD_W-1:0]  scratch, scratch_next;
  logic [STEP_W-1:0] step_cnt, step_next;
  logic [BCD_W-1:0]  bcd_next;
  logic              done_next;
  logic              busy_next;
  logic [BCD_W-1:0]  adjusted;
  logic [STEP_W-1:0] bit_idx;

  assign adjusted = dabble_adjust(scratch);
  // MSB of the captured value goes in first
  assign bit_idx  = STEP_W'(DATA_W - 1) - step_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      captured <= '0;
      scratch  <= '0;
      step_cnt <= '0;
      bcd      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      captured <= captured_next;
      scratch  <= scratch_next;
      step_cnt <= step_next;
      bcd      <= bcd_next;
      done     <= done_next;
      busy     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state;
    captured_next = captured;
    scratch_next  = scratch;
    step_next     = step_cnt;
    bcd_next      = bcd;
    done_next     = 1'b0;
    busy_next     = busy;
    unique case (state)
      ST_IDLE: begin
        // Comparing against the captured value (not the previous input)
        // means a change that arrived mid-conversion is picked up here.
        if (resultado != captured) begin
          captured_next = resultado;
          scratch_next  = '0;
          step_next     = '0;
          busy_next     = 1'b1;
          state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // After the last step one extra SHIFT cycle elapses before DONE,
        // which fixes the change-to-done latency at 16 edges.
        if (step_cnt == LAST_STEP) begin
          state_next = ST_DONE;
        end else begin
          scratch_next = {adjusted[BCD_W-2:0], captured[bit_idx]};
          step_next    = step_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        bcd_next   = scratch;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Display scan (runs independently of the converter)
  // --------------------------------------------------------------------------
  localparam int               CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);

  logic [CNT_W-1:0]  refresh_cnt;
  logic [2:0]        digit_idx;
  logic [DIGITS-1:0] blank;
  logic              zeros_above;
  logic [3:0]        digit_code;
  logic [6:0]        seg_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_LAST) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == IDX_LAST) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // A digit is blank when it and every digit above it are zero; the least
  // significant digit always shows, so a zero result reads "0".
  always_comb begin
    blank       = '0;
    zeros_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeros_above = zeros_above && (bcd[4*i +: 4] == 4'd0);
      blank[i]    = zeros_above;
    end
  end

  always_comb begin
    digit_code = CODE_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == 3'(i)) begin
        digit_code = blank[i] ? CODE_BLANK : bcd[4*i +: 4];
      end
    end
  end

  seg7_decode u_seg7_decode (
    .code (digit_code),
    .seg  (seg_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= ~DIGITS'(1);
      seg <= SEG_0;
    end else begin
      an  <= ~(DIGITS'(1) << digit_idx);
      seg <= seg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_display
// Description : Self-checking bench for result_display. Expected BCD values
//               and segment patterns come from decimal arithmetic on the
//               applied value; latencies are counted in clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] resultado = '0;
  logic [19:0] bcd;
  logic        done;
  logic        busy;
  logic [6:0]  seg;
  logic [4:0]  an;

  int checks = 0;
  int errors = 0;
  int last_val = 0;

  result_display #(.REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .resultado (resultado),
    .bcd       (bcd),
    .done      (done),
    .busy      (busy),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  // Decimal digits of v, packed 4 bits each
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Expected active-low pattern for decimal position pos of value v
  function automatic logic [6:0] ref_seg(input int v, input int pos);
    int p10;
    int d;
    p10 = 1;
    for (int i = 0; i < pos; i++) p10 = p10 * 10;
    if (pos != 0 && v < p10) return 7'b1111111;
    d = (v / p10) % 10;
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Apply v and expect bcd/done 16 edges after the first sampling edge
  task automatic convert_and_check(input int v, input string name);
    int lat;
    bit seen;
    bit stable_bad;
    bit busy_bad;
    @(negedge clk);
    resultado = 14'(v);
    lat = 0;
    seen = 0;
    stable_bad = 0;
    busy_bad = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1;
      end else begin
        if (bcd !== ref_bcd(last_val)) stable_bad = 1;
        if (busy !== 1'b1) busy_bad = 1;
      end
    end
    checks++;
    if (!seen || lat != 17) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (seen=%0d), expected 17", name, lat, seen);
    end
    checks++;
    if (bcd !== ref_bcd(v)) begin
      errors++;
      $display("FAIL %s bcd: got %05h, expected %05h", name, bcd, ref_bcd(v));
    end
    checks++;
    if (stable_bad || busy_bad) begin
      errors++;
      $display("FAIL %s during conversion: bcd_changed=%0d busy_low=%0d, expected 0 0", name, stable_bad, busy_bad);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy at done: got %b, expected 0", name, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done width: got %b one cycle later, expected 0", name, done);
    end
    last_val = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    resultado = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (an !== 5'b11110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset display: an=%b seg=%b, expected 11110 1000000", an, seg);
    end
    checks++;
    if (bcd !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset converter: bcd=%05h busy=%b done=%b, expected 00000 0 0", bcd, busy, done);
    end
    rst_n = 1'b1;
    last_val = 0;
  endtask

  task automatic test_single();
    convert_and_check(1234, "single_1234");
  endtask

  task automatic test_max();
    convert_and_check(16383, "max_16383");
    convert_and_check(0, "back_to_zero");
  endtask

  task automatic test_random();
    int v;
    int hits;
    for (int n = 0; n < 6; n++) begin
      v = int'($urandom_range(16383, 0));
      if (v == last_val) v = (v + 1) % 16384;
      convert_and_check(v, "random");
    end
    // Re-applying the captured value must not start a conversion
    @(negedge clk);
    resultado = 14'(last_val);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL same_value: busy/done seen %0d cycles, expected 0", hits);
    end
  endtask

  task automatic test_mid_change();
    int lat;
    int pulses;
    @(negedge clk);
    resultado = 14'd100;
    pulses = 0;
    for (lat = 1; lat <= 60; lat++) begin
      @(negedge clk);
      if (lat == 5) resultado = 14'd9999;
      if (done) begin
        pulses++;
        checks++;
        if (pulses == 1 && (lat != 17 || bcd !== ref_bcd(100))) begin
          errors++;
          $display("FAIL mid_change first: lat=%0d bcd=%05h, expected 17 %05h", lat, bcd, ref_bcd(100));
        end else if (pulses == 2 && (lat != 34 || bcd !== ref_bcd(9999))) begin
          errors++;
          $display("FAIL mid_change second: lat=%0d bcd=%05h, expected 34 %05h", lat, bcd, ref_bcd(9999));
        end else if (pulses > 2) begin
          errors++;
          $display("FAIL mid_change extra pulse: lat=%0d, expected none", lat);
        end
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL mid_change pulses: got %0d, expected 2", pulses);
    end
    last_val = 9999;
  endtask

  task automatic test_scan();
    logic [4:0] prev_an;
    bit aligned;
    int pos;
    convert_and_check(42, "scan_value_42");
    aligned = 0;
    prev_an = an;
    for (int i = 0; i < 50 && !aligned; i++) begin
      @(negedge clk);
      if (an === 5'b11110 && prev_an !== 5'b11110) aligned = 1;
      else prev_an = an;
    end
    checks++;
    if (!aligned) begin
      errors++;
      $display("FAIL scan align: an never entered 11110, last an=%b", an);
    end
    for (int k = 0; k < 20; k++) begin
      pos = k / 4;
      checks++;
      if (an !== ~(5'b00001 << pos) || seg !== ref_seg(42, pos)) begin
        errors++;
        $display("FAIL scan cycle %0d: an=%b seg=%b, expected %b %b", k, an, seg, ~(5'b00001 << pos), ref_seg(42, pos));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_shift();
    int hits;
    @(negedge clk);
    resultado = 14'd5000;
    repeat (7) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_shift precondition busy: got %b, expected 1", busy);
    end
    rst_n = 1'b0;
    resultado = '0;
    @(negedge clk);
    checks++;
    if (bcd !== 20'h0 || busy !== 1'b0 || done !== 1'b0 || an !== 5'b11110 || seg !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_mid_shift values: bcd=%05h busy=%b done=%b an=%b seg=%b, expected 00000 0 0 11110 1000000",
               bcd, busy, done, an, seg);
    end
    rst_n = 1'b1;
    last_val = 0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || bcd !== 20'h0) hits++;
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL reset_mid_shift aftermath: done/bcd activity %0d cycles, expected 0", hits);
    end
  endtask

  task automatic test_after_reset();
    convert_and_check(777, "after_reset_777");
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_random();
    test_mid_change();
    test_scan();
    test_reset_mid_shift();
    test_after_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
